// File: rtl/alu_ctrl.sv
// Multi-cycle issue controller for the combinational ALU: IDLE -> READ -> EXEC -> WB, 4-entry register file.
// Optional zero flag is built only when ALU_CTRL_ZFLAG_EN is defined; otherwise zflag is tied low.
module alu_ctrl #(
    parameter int DW    = 8,
    parameter int NREGS = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [15:0]   in_instr,
    input  logic          in_imm,
    output logic [3:0]    alu_op,
    output logic [DW-1:0] alu_a,
    output logic [DW-1:0] alu_b,
    input  logic [DW-1:0] alu_out,
    output logic          done,
    output logic [DW-1:0] result,
    output logic          zflag,
    input  logic [1:0]    dbg_addr,
    output logic [DW-1:0] dbg_data
);

    localparam logic [3:0] ALUOP_ADD = 4'h0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        EXEC = 2'd2,
        WB   = 2'd3
    } state_t;

    state_t          state_reg, state_next;
    logic [15:0]     instr_reg;
    logic            imm_sel_reg;
    logic [3:0]      op_reg;
    logic [DW-1:0]   a_reg, b_reg;
    logic [DW-1:0]   res_q;
    logic [DW-1:0]   result_reg;
    logic [DW-1:0]   rf_reg [NREGS];

    logic [1:0]      rd, ra, rb;
    logic [DW-1:0]   imm_val;
    logic            accept;

    assign rd      = instr_reg[11:10];
    assign ra      = instr_reg[9:8];
    assign rb      = instr_reg[1:0];
    assign imm_val = DW'(instr_reg[7:0]);

    assign accept   = in_valid && (state_reg == IDLE);
    assign in_ready = (state_reg == IDLE);
    assign done     = (state_reg == WB);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = READ;
            READ:    state_next = EXEC;
            EXEC:    state_next = WB;
            WB:      state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Instruction is only latched on the handshake; in_valid is ignored while busy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_reg   <= '0;
            imm_sel_reg <= 1'b0;
        end else if (accept) begin
            instr_reg   <= in_instr;
            imm_sel_reg <= in_imm;
        end
    end

    // ALU drive registers hold their values everywhere except READ.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_reg <= ALUOP_ADD;
            a_reg  <= '0;
            b_reg  <= '0;
        end else if (state_reg == READ) begin
            op_reg <= instr_reg[15:12];
            a_reg  <= rf_reg[ra];
            b_reg  <= imm_sel_reg ? imm_val : rf_reg[rb];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_q      <= '0;
            result_reg <= '0;
        end else if (state_reg == EXEC) begin
            res_q      <= alu_out;
            result_reg <= alu_out;
        end
    end

    // One write port: each entry loads res_q at the WB closing edge when addressed by rd.
    genvar gi;
    generate
        for (gi = 0; gi < NREGS; gi++) begin : g_rf
            localparam logic [1:0] IDX = 2'(gi);
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rf_reg[gi] <= '0;
                end else if (state_reg == WB && rd == IDX) begin
                    rf_reg[gi] <= res_q;
                end
            end
        end
    endgenerate

`ifdef ALU_CTRL_ZFLAG_EN
    logic zflag_reg;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zflag_reg <= 1'b0;
        end else if (state_reg == WB) begin
            zflag_reg <= (res_q == '0);
        end
    end
    assign zflag = zflag_reg;
`else
    assign zflag = 1'b0;
`endif

    assign alu_op   = op_reg;
    assign alu_a    = a_reg;
    assign alu_b    = b_reg;
    assign result   = result_reg;
    assign dbg_data = rf_reg[dbg_addr];

endmodule

// File: tb/tb_alu_ctrl.sv
// Scoreboard bench for alu_ctrl: stimulus pushes expected writebacks, a monitor pops them on done.
module tb_alu_ctrl;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [15:0]   in_instr = '0;
    logic          in_imm = 1'b0;
    logic [3:0]    alu_op;
    logic [DW-1:0] alu_a, alu_b, alu_out;
    logic          done;
    logic [DW-1:0] result;
    logic          zflag;
    logic [1:0]    dbg_addr = '0;
    logic [DW-1:0] dbg_data;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    alu_ctrl #(.DW(DW), .NREGS(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_imm(in_imm),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_out(alu_out),
        .done(done), .result(result), .zflag(zflag),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural ALU; undefined codes return an arbitrary but deterministic value.
    function automatic logic [7:0] alu_fn(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            4'd5:    return a << b[2:0];
            4'd6:    return a >> b[2:0];
            default: return a ^ b ^ 8'h5a;
        endcase
    endfunction

    assign alu_out = alu_fn(alu_op, alu_a, alu_b);

    typedef struct {
        logic [7:0] res;
        logic [3:0] op;
        logic [7:0] a;
        logic [7:0] b;
        int         dcyc;
        logic       z;
    } exp_t;

    exp_t       q[$];
    exp_t       mon_e;
    logic [7:0] mrf [4];
    logic       z_pending = 1'b0;
    logic       z_exp = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: one line per completed writeback.
    always @(negedge clk) begin
        if (z_pending) begin
            check("zflag", {31'd0, zflag}, {31'd0, z_exp});
            z_pending = 1'b0;
        end
        if (rst_n && done) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got done=1 expected no writeback pending (t=%0t)", $time);
            end else begin
                mon_e = q.pop_front();
                $display("wb: op=%0d a=%0d b=%0d result=%0d cycle=%0d", alu_op, alu_a, alu_b, result, cyc);
                check("result", {24'd0, result}, {24'd0, mon_e.res});
                check("alu_op", {28'd0, alu_op}, {28'd0, mon_e.op});
                check("alu_a",  {24'd0, alu_a},  {24'd0, mon_e.a});
                check("alu_b",  {24'd0, alu_b},  {24'd0, mon_e.b});
                check("done_cycle", cyc, mon_e.dcyc);
                z_pending = 1'b1;
                z_exp = mon_e.z;
            end
        end
    end

    task automatic send(input logic [3:0] op, input logic [1:0] rd, input logic [1:0] ra,
                        input logic [7:0] immb, input logic use_imm, input logic hold,
                        input logic track, output int acc, output int waits);
        exp_t e;
        waits = 0;
        @(negedge clk);
        in_instr = {op, rd, ra, immb};
        in_imm   = use_imm;
        in_valid = 1'b1;
        while (!in_ready && waits < 50) begin
            waits++;
            @(negedge clk);
        end
        if (!in_ready) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: in_ready=0 expected 1 within 50 cycles");
        end
        acc = cyc + 1;
        e.op   = op;
        e.a    = mrf[ra];
        e.b    = use_imm ? immb : mrf[immb[1:0]];
        e.res  = alu_fn(op, e.a, e.b);
        e.dcyc = acc + 2;
`ifdef ALU_CTRL_ZFLAG_EN
        e.z    = (e.res == 8'd0);
`else
        e.z    = 1'b0;
`endif
        if (track) begin
            mrf[rd] = e.res;
            q.push_back(e);
        end
        @(posedge clk);
        #1;
        if (!hold) in_valid = 1'b0;
    endtask

    task automatic check_rf();
        int n = 0;
        while (q.size() != 0 && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: pending=%0d expected 0", q.size());
            q.delete();
        end
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            dbg_addr = 2'(i);
            #1;
            check($sformatf("rf[%0d]", i), {24'd0, dbg_data}, {24'd0, mrf[i]});
        end
    endtask

    int acc1, acc2, w1, w2;

    initial begin
        for (int i = 0; i < 4; i++) mrf[i] = 8'd0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("reset_alu_op", {28'd0, alu_op}, 32'd0);
        check("reset_alu_a", {24'd0, alu_a}, 32'd0);
        check("reset_result", {24'd0, result}, 32'd0);
        check("reset_zflag", {31'd0, zflag}, 32'd0);
        check_rf();

        // Immediate ADD chain, then register SUB to zero
        send(4'd0, 2'd1, 2'd0, 8'd5, 1'b1, 1'b0, 1'b1, acc1, w1);
        check_rf();
        send(4'd0, 2'd2, 2'd1, 8'd7, 1'b1, 1'b0, 1'b1, acc1, w1);
        check_rf();
        send(4'd1, 2'd3, 2'd2, 8'd2, 1'b0, 1'b0, 1'b1, acc1, w1);
        check_rf();

        // Destination equals source
        send(4'd0, 2'd1, 2'd1, 8'd2, 1'b0, 1'b0, 1'b1, acc1, w1);
        check_rf();
        check("r1_is_17", {24'd0, mrf[1]}, 32'd17);

        // Wrap-around: 200 + 100 = 44 mod 256
        send(4'd0, 2'd1, 2'd0, 8'd200, 1'b1, 1'b0, 1'b1, acc1, w1);
        send(4'd0, 2'd2, 2'd1, 8'd100, 1'b1, 1'b0, 1'b1, acc1, w1);
        check_rf();

        // Back-to-back with in_valid held high
        send(4'd4, 2'd0, 2'd1, 8'd3, 1'b0, 1'b1, 1'b1, acc1, w1);
        send(4'd2, 2'd3, 2'd0, 8'h0f, 1'b1, 1'b0, 1'b1, acc2, w2);
        check("b2b_accept_gap", acc2 - acc1, 32'd4);
        check("b2b_busy_cycles", w2, 32'd3);
        check_rf();

        // Reset during EXEC aborts with no writeback
        send(4'd0, 2'd1, 2'd0, 8'd9, 1'b1, 1'b0, 1'b0, acc1, w1);
        @(negedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("abort_in_ready", {31'd0, in_ready}, 32'd1);
            check("abort_done", {31'd0, done}, 32'd0);
            @(negedge clk);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) mrf[i] = 8'd0;
        check_rf();
        check("abort_zflag", {31'd0, zflag}, 32'd0);

        // Randomised traffic, including undefined opcodes and occasional back-to-back issue
        for (int n = 0; n < 40; n++) begin
            send(4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                 8'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
                 1'b1, acc1, w1);
        end
        @(negedge clk);
        in_valid = 1'b0;
        check_rf();

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_ctrl.md
# alu_ctrl

Multi-cycle issue controller that drives the combinational `alu` from the other side of its interface. It accepts one instruction at a time over a valid/ready handshake and reads operands from an internal register file. It presents `aluop`/`a`/`b` to the ALU, captures the ALU result and writes it back. It sits between the instruction fetch path and the `alu` instance in the simple CPU datapath.

## Interface
Parameters:
- `DW`, 8: datapath width; must match the ALU operand width.
- `NREGS`, 4: register file depth; fixed at 4 because register indices are 2 bits.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous assert, active-low reset.
- `in_valid`  in  1  instruction present.
- `in_ready`  out  1  controller can accept an instruction.
- `in_instr`  in  16  [15:12] aluop, [11:10] rd, [9:8] ra, [7:0] imm, or rb in [1:0].
- `in_imm`  in  1  1: operand B = imm; 0: operand B = rf[rb].
- `alu_op`  out  4  to ALU `aluop`; encodings from `defines.v` (`ALUOP_ADD`, `ALUOP_SUB`, ...).
- `alu_a`  out  DW  to ALU operand a.
- `alu_b`  out  DW  to ALU operand b.
- `alu_out`  in  DW  from ALU result, combinational.
- `done`  out  1  one-cycle pulse at writeback.
- `result`  out  DW  last written result; held until the next writeback.
- `zflag`  out  1  zero flag (see Configuration).
- `dbg_addr`  in  2  debug register read address.
- `dbg_data`  out  DW  combinational `rf[dbg_addr]`.

## Operation
- States: IDLE, READ, EXEC, WB, encoded as a registered 2-bit state.
- IDLE
  - `in_ready`=1.
  - On `in_valid & in_ready`, latch `in_instr` and `in_imm`, then go to READ.
- READ
  - Register `alu_op`=instr[15:12] and `alu_a`=rf[ra].
  - Register `alu_b`=imm when `in_imm`=1, else rf[rb].
  - Go to EXEC.
- EXEC
  - ALU inputs are stable; capture `alu_out` into the internal `res_q`.
  - Go to WB.
- WB
  - `done`=1; `result`=`res_q`.
  - At the closing edge, `rf[rd]`←`res_q`, then go to IDLE.
- `in_ready` is low in READ, EXEC and WB. `in_valid` is ignored outside IDLE; the instruction is only consumed on the handshake.
- All registers, including r0, are writable.
- Arithmetic is performed by the ALU modulo 2^DW. The controller does no width extension and applies no saturation.
- `alu_op`/`alu_a`/`alu_b` hold their last values outside READ.
- Unknown aluop codes are passed through unchanged. The result is whatever the ALU returns.

## Timing
- Handshake at edge k:
  - READ during cycle k+1, EXEC during k+2, WB during k+3 (`done`=1).
  - Register visible on `dbg_data` from cycle k+4.
- Throughput is one instruction per 4 cycles. With `in_valid` held high, the next acceptance occurs at edge k+4.
- Reset values:
  - state=IDLE, `in_ready`=1, `done`=0.
  - `alu_op`=`ALUOP_ADD`.
  - `alu_a`, `alu_b`, `result`, `res_q` = 0.
  - all rf=0, `zflag`=0.
- Reset asserted mid-operation aborts immediately. No register-file write occurs and `done` is not pulsed.
- rd equal to ra or rb is legal: operands were sampled in READ, before the write.

## Configuration
- `ALU_CTRL_ZFLAG_EN` defined:
  - `zflag` is a register updated at the WB closing edge to (`res_q`==0).
  - It holds between writebacks and resets to 0.
- `ALU_CTRL_ZFLAG_EN` undefined: `zflag` is tied to 0 and no flag logic is built.

## Test plan
- After reset, check outputs:
  - `in_ready`=1, `done`=0, `alu_op`=`ALUOP_ADD`, all rf=0.
- Immediate ADD then register SUB:
  - ADD rd=1 ra=0 imm=5 (`in_imm`=1) → `done` exactly 3 cycles after acceptance, `result`=5, r1=5.
  - Then ADD rd=2 ra=1 imm=7 → r2=12.
  - Then SUB rd=3 ra=2 rb=2 (`in_imm`=0) → r3=0.
  - With `ALU_CTRL_ZFLAG_EN`, `zflag`=1.
- Register-register ADD with destination equal to source: r1=5, r2=12; ADD rd=1 ra=1 rb=2 → r1=17 and `alu_a`=5 in EXEC.
- Wrap-around: r1=200; ADD rd=2 ra=1 imm=100 → r2=44; with `ALU_CTRL_ZFLAG_EN`, `zflag`=0.
- Back-to-back: `in_valid` held high with two instructions.
  - The second is accepted exactly 4 cycles after the first.
  - `in_ready`=0 for 3 cycles in between.
  - Both results are written.
- Reset during EXEC of ADD rd=1 ra=0 imm=9 → r1=0, `done` never pulses, and `in_ready`=1 while reset is held.
